// File: rtl/k6502_bus_tracer_pkg.sv
// k6502_defs: shared state encodings, record layout and defaults for the bus tracer.
package k6502_defs;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN = 2'd1;
  localparam logic [1:0] ST_HALTED = 2'd2;
  localparam logic KIND_WRITE = 1'b1;
  localparam logic KIND_FETCH = 1'b0;
  localparam logic [15:0] HALT_ADDR_DEF = 16'hDEAD;
  // record = {kind, a, d, ts}, ts in the low bits
  localparam int REC_TS_LSB = 0;
  function automatic int rec_d_lsb(int ts_w);
    return ts_w;
  endfunction
  function automatic int rec_a_lsb(int ts_w, int data_w);
    return ts_w + data_w;
  endfunction
  function automatic int rec_kind_bit(int ts_w, int data_w, int addr_w);
    return ts_w + data_w + addr_w;
  endfunction
endpackage

// File: rtl/k6502_bus_tracer_if.sv
// k6502_bus_tracer_if: snooped CPU bus plus the trace record stream.
interface k6502_bus_tracer_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8,
  parameter int TS_W = 16
);
  logic [ADDR_W-1:0] a;
  logic [DATA_W-1:0] d;
  logic rw;
  logic sync;
  logic out_valid;
  logic out_ready;
  logic [ADDR_W+DATA_W+TS_W:0] out_data;
  modport master(output a, d, rw, sync, out_ready, input out_valid, out_data);
  modport slave(input a, d, rw, sync, out_ready, output out_valid, out_data);
endinterface

// File: rtl/k6502_bus_tracer_fifo.sv
// k6502_sync_fifo: synchronous FIFO; head reads as zero when empty, push into a full FIFO succeeds only alongside a pop.
module k6502_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  always_comb begin
    empty = count == '0;
    full = count == (AW+1)'(DEPTH);
    do_pop = pop && !empty;
    do_push = push && (!full || do_pop);
    rdata = empty ? '0 : mem[rd_ptr];
  end
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      wr_ptr <= do_push ? wr_ptr + 1'b1 : wr_ptr;
      rd_ptr <= do_pop ? rd_ptr + 1'b1 : rd_ptr;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr] <= wdata;
endmodule

// File: rtl/k6502_bus_tracer.sv
// k6502_bus_tracer: captures CPU writes and opcode fetches into a timestamped FIFO, freezing on a halt-address write.
module k6502_bus_tracer import k6502_defs::*; #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8,
  parameter int DEPTH = 16,
  parameter int TS_W = 16,
  parameter int CNT_W = 32,
  parameter logic [ADDR_W-1:0] HALT_ADDR = ADDR_W'(HALT_ADDR_DEF)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic                     clear,
  input  logic [1:0]               mode,
  k6502_bus_tracer_if.slave        bus,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     halted,
  output logic [CNT_W-1:0]         cycle_cnt
);
  localparam int REC_W = rec_kind_bit(TS_W, DATA_W, ADDR_W) + 1;
  logic [1:0] state;
  logic sync_q, run, wr_ev, fe_ev, push, pop, full, empty;
  logic [REC_W-1:0] rec;
  always_comb begin
    run = state == ST_RUN;
    halted = state == ST_HALTED;
    wr_ev = run && bus.rw && mode[0];
    fe_ev = run && mode[1] && bus.sync && !sync_q;
    push = (wr_ev || fe_ev) && !clear;
    pop = bus.out_valid && bus.out_ready;
    bus.out_valid = !empty;
    rec = wr_ev ? {KIND_WRITE, bus.a, bus.d, cycle_cnt[TS_W-1:0]}
                : {KIND_FETCH, bus.a, {DATA_W{1'b0}}, cycle_cnt[TS_W-1:0]};
  end
  // halt detection looks only at the bus, not at mode or FIFO space
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      state <= ST_IDLE;
      overflow <= 1'b0;
      cycle_cnt <= '0;
    end else begin
      state <= (state == ST_IDLE && en) ? ST_RUN :
               (run && bus.rw && bus.a == HALT_ADDR) ? ST_HALTED : state;
      cycle_cnt <= run ? cycle_cnt + 1'b1 : cycle_cnt;
      overflow <= overflow || (wr_ev && fe_ev) || (push && full && !pop);
    end
  end
  always_ff @(posedge clk)
    sync_q <= rst_n && bus.sync;
  k6502_sync_fifo #(.WIDTH(REC_W), .DEPTH(DEPTH)) fifo (
    .clk(clk),
    .rst_n(rst_n),
    .clear(clear),
    .push(push),
    .pop(pop),
    .wdata(rec),
    .rdata(bus.out_data),
    .full(full),
    .empty(empty),
    .count(count)
  );
endmodule

// File: tb/tb_k6502_bus_tracer.sv
// tb_k6502_bus_tracer: directed stimulus with a record scoreboard popped by an independent monitor.
module tb_k6502_bus_tracer;
  import k6502_defs::*;
  localparam int AW = 16, DW = 8, TW = 16, CW = 32, DEPTH = 4, RW = AW + DW + TW + 1;
  logic clk = 0, rst_n = 0, en = 0, clear = 0;
  logic [1:0] mode = 2'b00;
  logic [2:0] count;
  logic overflow, halted;
  logic [CW-1:0] cycle_cnt;
  int errs = 0, checks = 0, m_cnt = 0;
  bit m_run = 0;
  logic [RW-1:0] exp_q[$];
  logic [RW-1:0] mon_e;

  k6502_bus_tracer_if #(.ADDR_W(AW), .DATA_W(DW), .TS_W(TW)) bus();
  k6502_bus_tracer #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .TS_W(TW), .CNT_W(CW),
                     .HALT_ADDR(16'hDEAD)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .clear(clear), .mode(mode), .bus(bus),
    .count(count), .overflow(overflow), .halted(halted), .cycle_cnt(cycle_cnt)
  );

  always #5 clk = ~clk;

  // monitor: every accepted head is compared against the scoreboard
  initial forever begin
    @(negedge clk);
    if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errs++;
        $display("FAIL record: unexpected %h, scoreboard empty", bus.out_data);
      end else begin
        mon_e = exp_q.pop_front();
        if (bus.out_data !== mon_e) begin
          errs++;
          $display("FAIL record: got %h expected %h", bus.out_data, mon_e);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    if (m_run) m_cnt++;
    #1;
  endtask

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] d, input bit keep);
    bus.rw = 1'b1;
    bus.a = a;
    bus.d = d;
    if (keep) exp_q.push_back({1'b1, a, d, m_cnt[15:0]});
    tick();
    bus.rw = 1'b0;
  endtask

  task automatic start(input logic [1:0] md);
    mode = md;
    en = 1'b1;
    tick();
    en = 1'b0;
    m_run = 1;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    m_run = 0;
    m_cnt = 0;
    exp_q.delete();
  endtask

  initial begin
    bus.a = '0; bus.d = '0; bus.rw = 1'b0; bus.sync = 1'b0; bus.out_ready = 1'b0;
    tick(); tick();
    chk("rst out_valid", bus.out_valid, 0);
    chk("rst count", count, 0);
    chk("rst overflow", overflow, 0);
    chk("rst halted", halted, 0);
    chk("rst cycle_cnt", cycle_cnt, 0);
    chk("rst out_data", bus.out_data, 0);
    rst_n = 1'b1;
    tick();
    // writes only
    start(2'b01);
    wr(16'h0010, 8'hAA, 1);
    wr(16'h0011, 8'h55, 1);
    chk("wr count", count, 2);
    chk("wr cycle_cnt", cycle_cnt, m_cnt);
    bus.out_ready = 1'b1;
    tick(); tick();
    chk("wr drained", count, 0);
    // fetches only: held sync gives one record, d is forced to zero
    mode = 2'b10;
    bus.d = 8'hEA;
    bus.sync = 1'b1; bus.a = 16'h8000;
    exp_q.push_back({1'b0, 16'h8000, 8'h00, m_cnt[15:0]});
    tick(); tick();
    bus.sync = 1'b0; tick();
    bus.sync = 1'b1; bus.a = 16'h8003;
    exp_q.push_back({1'b0, 16'h8003, 8'h00, m_cnt[15:0]});
    tick();
    bus.sync = 1'b0; tick(); tick();
    chk("fetch drained", count, 0);
    chk("fetch overflow", overflow, 0);
    // write and fetch together: write kept, fetch dropped
    mode = 2'b11;
    bus.sync = 1'b1;
    wr(16'h1234, 8'h77, 1);
    bus.sync = 1'b0;
    chk("collide overflow", overflow, 1);
    tick();
    chk("collide count", count, 0);
    do_clear();
    chk("clear overflow", overflow, 0);
    chk("clear cycle_cnt", cycle_cnt, 0);
    // overflow with consumer stalled
    bus.out_ready = 1'b0;
    start(2'b01);
    for (int i = 0; i < 6; i++) wr(16'h0100 + 16'(i), 8'h10 + 8'(i), i < DEPTH);
    chk("ovf count", count, 4);
    chk("ovf overflow", overflow, 1);
    bus.out_ready = 1'b1;
    tick(); tick(); tick(); tick();
    chk("ovf drained", count, 0);
    do_clear();
    // full boundary: push and pop in the same cycle
    bus.out_ready = 1'b0;
    start(2'b01);
    for (int i = 0; i < 4; i++) wr(16'h0180 + 16'(i), 8'h80 + 8'(i), 1);
    chk("full count", count, 4);
    bus.out_ready = 1'b1;
    wr(16'h0184, 8'h84, 1);
    chk("full pushpop count", count, 4);
    chk("full pushpop overflow", overflow, 0);
    tick(); tick(); tick(); tick();
    chk("full drained", count, 0);
    // halt: halt write captured, then capture frozen
    bus.out_ready = 1'b0;
    do_clear();
    start(2'b01);
    wr(16'h0020, 8'h11, 1);
    wr(16'h0021, 8'h22, 1);
    wr(16'hDEAD, 8'h01, 1);
    m_run = 0;
    chk("halt halted", halted, 1);
    chk("halt count", count, 3);
    chk("halt cycle_cnt", cycle_cnt, m_cnt);
    wr(16'h0200, 8'h33, 0);
    wr(16'h0201, 8'h44, 0);
    chk("halted no push", count, 3);
    chk("halted cnt frozen", cycle_cnt, 3);
    en = 1'b1; tick(); en = 1'b0;
    chk("halted ignores en", halted, 1);
    do_clear();
    chk("clr count", count, 0);
    chk("clr valid", bus.out_valid, 0);
    chk("clr halted", halted, 0);
    chk("clr cycle_cnt", cycle_cnt, 0);
    // reset mid-run
    start(2'b01);
    wr(16'h0300, 8'h5A, 1);
    wr(16'h0301, 8'h5B, 1);
    rst_n = 1'b0;
    tick();
    exp_q.delete();
    m_run = 0; m_cnt = 0;
    chk("mid rst valid", bus.out_valid, 0);
    chk("mid rst count", count, 0);
    chk("mid rst cycle_cnt", cycle_cnt, 0);
    chk("mid rst out_data", bus.out_data, 0);
    rst_n = 1'b1;
    wr(16'h0400, 8'h01, 0);
    chk("idle no capture", count, 0);
    chk("scoreboard empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/k6502_bus_tracer.md
Name: k6502_bus_tracer

Overview:
- Synthesizable bus-trace capture unit that sits on the k6502 address/data/rw/sync bus alongside rom and sram.
- Records CPU write cycles and opcode-fetch events into a parametrised FIFO, each tagged with a cycle timestamp.
- Detects a write to a programmable halt address and freezes capture, so the bench or an on-chip debug reader can drain the trace.
- Generalises the bench-only write/sync logging and halt-on-0xDEAD behaviour into a reusable block with filtering, back-pressure and overflow reporting.

Parameters:
ADDR_W, 16, CPU address width
DATA_W, 8, CPU data width
DEPTH, 16, FIFO entries; power of two, minimum 2
TS_W, 16, timestamp bits stored per record
CNT_W, 32, free-running cycle counter width; must be at least TS_W
HALT_ADDR, 16'hDEAD, a write to this address halts capture

Ports:
clk  in  1  clock; all state changes on posedge
rst_n  in  1  synchronous active-low reset
en  in  1  start capture; sampled only in IDLE
clear  in  1  flush FIFO, clear flags, return to IDLE
mode  in  2  bit0 = capture writes; bit1 = capture fetches
a  in  ADDR_W  CPU address bus
d  in  DATA_W  CPU data bus (value sampled at posedge)
rw  in  1  codebase convention: 1 = write cycle
sync  in  1  high during opcode fetch
out_valid  out  1  FIFO head valid
out_ready  in  1  consumer accepts head
out_data  out  1+ADDR_W+DATA_W+TS_W  record {kind, a, d, ts}; kind 1 = write, 0 = fetch
count  out  $clog2(DEPTH)+1  current occupancy
overflow  out  1  sticky; a record was dropped
halted  out  1  high in HALTED
cycle_cnt  out  CNT_W  cycles elapsed since capture started

Behaviour:
- Reset (rst_n=0 at posedge):
  - State = IDLE.
  - FIFO empty: out_valid=0, count=0.
  - overflow=0, halted=0, cycle_cnt=0.
  - out_data=0.
  - sync_q=0.
  - Reset mid-capture discards all FIFO contents.
- States: IDLE, RUN, HALTED.
  - IDLE -> RUN when en=1.
  - RUN -> HALTED on a write to HALT_ADDR.
  - Any state -> IDLE when clear=1, which also empties the FIFO and zeroes overflow and cycle_cnt.
  - clear has priority over every other event in the same cycle.
- cycle_cnt:
  - Increments by 1 every cycle in RUN; wraps modulo 2^CNT_W.
  - Holds in IDLE and HALTED.
  - ts field = cycle_cnt[TS_W-1:0] in the cycle the event is sampled.
- Write event: RUN && rw=1 && mode[0]. One record per write cycle.
- Fetch event:
  - RUN && mode[1] && sync=1 && sync_q=0, where sync_q is sync registered every cycle.
  - Rising-edge detection gives exactly one record per instruction.
  - Record carries d=0 and a = the fetch address.
- Simultaneous write and fetch in one cycle: the write record is pushed, the fetch is dropped, and overflow is set.
- Halt:
  - A write to HALT_ADDR in RUN is recorded if mode[0]=1 and there is space.
  - State becomes HALTED the next cycle and halted=1.
  - Halt detection is independent of mode and of FIFO space.
  - No pushes occur in HALTED; draining continues.
- FIFO:
  - Push latency is 1: an event sampled at edge N makes out_valid=1 after edge N, if the FIFO was empty.
  - Pop happens on out_valid && out_ready.
  - Full with push and no pop: the record is dropped and overflow is set.
  - Full with push and pop in the same cycle: both succeed and count is unchanged.
  - Empty with pop: ignored.
  - Pointers wrap modulo DEPTH.
  - out_data stays stable while out_valid=1 and out_ready=0.
- en asserted outside IDLE has no effect.
- mode is sampled every cycle; changing it mid-RUN affects the next event only.

Decomposition:
- Shared package k6502_defs:
  - state encodings ST_IDLE, ST_RUN, ST_HALTED;
  - record field offsets and the KIND_WRITE / KIND_FETCH constants;
  - the default HALT_ADDR.
- One sub-module, k6502_sync_fifo:
  - parameters WIDTH and DEPTH;
  - push/pop with full, empty and count outputs.
- The tracer owns event detection, the state machine, the counter and overflow.

Test Plan:
- Writes only: mode=01, en=1, then writes 0x0010=0xAA and 0x0011=0x55 on consecutive cycles -> two records {1,0010,AA,ts}, {1,0011,55,ts+1}; count=2.
- Fetches only: mode=10, sync held high 2 cycles at a=0x8000, then a pulse at 0x8003 -> exactly two fetch records, addresses 8000 and 8003.
- Overflow: DEPTH=4, out_ready=0, 6 writes -> count=4, overflow=1; the FIFO holds the first 4 writes; then out_ready=1 drains 4 records in order.
- Full boundary: full FIFO with push and pop in the same cycle -> count stays 4, overflow stays 0.
- Halt: write 0xDEAD=0x01 -> that record is captured, halted=1 the next cycle, and cycle_cnt freezes; further writes add nothing.
- Reset and clear: clear=1 while HALTED with 3 entries -> IDLE, count=0, overflow=0, cycle_cnt=0; rst_n=0 mid-RUN -> all outputs return to reset values the next cycle.
